// File: rtl/game_flow_ctrl_if.sv
// Control bundle between the game sequencer and the key/player side.
// The slave modport is the sequencer's view; the master modport drives keys and status.
interface game_flow_ctrl_if;
  logic       key_up;
  logic       key_down;
  logic       key_speed;
  logic       key_confirm;
  logic       key_back;
  logic       failed;
  logic       song_done;
  logic       in_animate_area;
  logic       animate_finish;
  logic       menu_enabled;
  logic       new_signal;
  logic       animate_pixel_disabled;
  logic       reset_restartable;
  logic       play_game_out;
  logic [1:0] song;
  logic [2:0] speed;
  logic       result_won;
  logic [2:0] state_dbg;

  modport slave (
    input  key_up, key_down, key_speed, key_confirm, key_back,
    input  failed, song_done, in_animate_area, animate_finish,
    output menu_enabled, new_signal, animate_pixel_disabled,
    output reset_restartable, play_game_out, song, speed, result_won, state_dbg
  );

  modport master (
    output key_up, key_down, key_speed, key_confirm, key_back,
    output failed, song_done, in_animate_area, animate_finish,
    input  menu_enabled, new_signal, animate_pixel_disabled,
    input  reset_restartable, play_game_out, song, speed, result_won, state_dbg
  );
endinterface

// File: rtl/game_flow_ctrl.sv
// Game sequencer: menu -> intro -> arm -> play -> result -> retry/menu.
// All outputs are registered from the next-state decode so they change on the entering edge.
module game_flow_ctrl #(
  parameter int NUM_SONGS   = 4,
  parameter int SPEED_MAX   = 7,
  parameter int RST_PULSE   = 4,
  parameter int RESULT_HOLD = 250000000
) (
  input  logic          i_clk,
  input  logic          i_reset_out,
  game_flow_ctrl_if.slave io_gf
);
  localparam logic [2:0] ST_MENU   = 3'd0;
  localparam logic [2:0] ST_INTRO  = 3'd1;
  localparam logic [2:0] ST_ARM    = 3'd2;
  localparam logic [2:0] ST_PLAY   = 3'd3;
  localparam logic [2:0] ST_RESULT = 3'd4;

  localparam int CNT_MAX = (RESULT_HOLD > RST_PULSE) ? RESULT_HOLD : RST_PULSE;
  localparam int CNT_W   = $clog2(CNT_MAX) + 1;

  localparam logic [CNT_W-1:0] ARM_LAST  = CNT_W'(RST_PULSE - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(RESULT_HOLD - 1);
  localparam logic [1:0]       SONG_LAST = 2'(NUM_SONGS - 1);
  localparam logic [2:0]       SPD_LAST  = 3'(SPEED_MAX);

  logic [2:0]       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [1:0]       r_song;
  logic [2:0]       r_speed;
  logic             r_won;
  logic             r_menu_en;
  logic             r_new_sig;
  logic             r_apd;
  logic             r_rst_rs;
  logic             r_play;

  logic [2:0] w_nxt;
  logic [1:0] w_song;
  logic [2:0] w_speed;
  logic       w_won;

  always_comb begin
    w_nxt   = ST_MENU;
    w_song  = r_song;
    w_speed = r_speed;
    w_won   = r_won;
    case (r_state)
      ST_MENU: begin
        if (io_gf.key_confirm) begin
          w_nxt = ST_INTRO;
        end else begin
          w_nxt = ST_MENU;
          if (io_gf.key_up && !io_gf.key_down)
            w_song = (r_song == SONG_LAST) ? 2'd0 : r_song + 2'd1;
          else if (io_gf.key_down && !io_gf.key_up)
            w_song = (r_song == 2'd0) ? SONG_LAST : r_song - 2'd1;
          if (io_gf.key_speed)
            w_speed = (r_speed >= SPD_LAST) ? 3'd1 : r_speed + 3'd1;
        end
      end
      ST_INTRO: begin
        // r_new_sig is high exactly in the first INTRO cycle, where finish is not yet trusted
        if (io_gf.key_back)                         w_nxt = ST_MENU;
        else if (io_gf.animate_finish && !r_new_sig) w_nxt = ST_ARM;
        else                                        w_nxt = ST_INTRO;
      end
      ST_ARM: w_nxt = (r_cnt == ARM_LAST) ? ST_PLAY : ST_ARM;
      ST_PLAY: begin
        if (io_gf.song_done) begin
          w_nxt = ST_RESULT;
          w_won = 1'b1;
        end else if (io_gf.failed) begin
          w_nxt = ST_RESULT;
          w_won = 1'b0;
        end else if (io_gf.key_back) begin
          w_nxt = ST_MENU;
        end else begin
          w_nxt = ST_PLAY;
        end
      end
      ST_RESULT: begin
        if (io_gf.key_confirm)                          w_nxt = ST_ARM;
        else if (io_gf.key_back || r_cnt == HOLD_LAST)  w_nxt = ST_MENU;
        else                                            w_nxt = ST_RESULT;
      end
      default: w_nxt = ST_MENU;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset_out) begin
      r_state   <= ST_MENU;
      r_cnt     <= '0;
      r_song    <= 2'd0;
      r_speed   <= 3'd1;
      r_won     <= 1'b0;
      r_menu_en <= 1'b1;
      r_new_sig <= 1'b0;
      r_apd     <= 1'b0;
      r_rst_rs  <= 1'b0;
      r_play    <= 1'b0;
    end else begin
      r_state   <= w_nxt;
      r_song    <= w_song;
      r_speed   <= w_speed;
      r_won     <= w_won;
      r_menu_en <= (w_nxt == ST_MENU);
      r_new_sig <= (w_nxt == ST_INTRO) && (r_state != ST_INTRO);
      r_apd     <= (w_nxt == ST_INTRO) && io_gf.in_animate_area;
      r_rst_rs  <= (w_nxt == ST_ARM);
      r_play    <= (w_nxt == ST_PLAY);
      // Restart on every state change, so ARM and RESULT each count from 0 on entry
      if (w_nxt != r_state)
        r_cnt <= '0;
      else if (r_state == ST_ARM || r_state == ST_RESULT)
        r_cnt <= r_cnt + 1'b1;
    end
  end

  assign io_gf.menu_enabled           = r_menu_en;
  assign io_gf.new_signal             = r_new_sig;
  assign io_gf.animate_pixel_disabled = r_apd;
  assign io_gf.reset_restartable      = r_rst_rs;
  assign io_gf.play_game_out          = r_play;
  assign io_gf.song                   = r_song;
  assign io_gf.speed                  = r_speed;
  assign io_gf.result_won             = r_won;
  assign io_gf.state_dbg              = r_state;
endmodule

// File: tb/tb_game_flow_ctrl.sv
// Directed bench for game_flow_ctrl with a short result hold.
module tb_game_flow_ctrl;
  logic clk;
  logic rst;
  int   errors;
  int   checks;

  game_flow_ctrl_if u_if ();

  game_flow_ctrl #(
    .NUM_SONGS(4), .SPEED_MAX(7), .RST_PULSE(4), .RESULT_HOLD(10)
  ) u_dut (
    .i_clk(clk),
    .i_reset_out(rst),
    .io_gf(u_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // From MENU: confirm, hold animate_finish, and wait out the ARM pulse.
  task automatic go_play();
    u_if.key_confirm = 1'b1;
    tick();
    u_if.key_confirm = 1'b0;
    u_if.animate_finish = 1'b1;
    tick();
    tick();
    u_if.animate_finish = 1'b0;
    repeat (4) tick();
  endtask

  int n;

  initial begin
    errors = 0;
    checks = 0;
    rst = 1'b1;
    u_if.key_up = 1'b0; u_if.key_down = 1'b0; u_if.key_speed = 1'b0;
    u_if.key_confirm = 1'b0; u_if.key_back = 1'b0;
    u_if.failed = 1'b0; u_if.song_done = 1'b0;
    u_if.in_animate_area = 1'b0; u_if.animate_finish = 1'b0;
    tick();
    tick();
    rst = 1'b0;

    chk("rst_state", 32'(u_if.state_dbg), 0);
    chk("rst_song",  32'(u_if.song), 0);
    chk("rst_speed", 32'(u_if.speed), 1);
    chk("rst_menu",  32'(u_if.menu_enabled), 1);
    chk("rst_outs",  {27'd0, u_if.new_signal, u_if.animate_pixel_disabled,
                      u_if.reset_restartable, u_if.play_game_out, u_if.result_won}, 0);

    // song/speed selection with wrap
    for (int i = 0; i < 5; i++) begin u_if.key_up = 1'b1; tick(); u_if.key_up = 1'b0; end
    chk("song_up5", 32'(u_if.song), 1);
    for (int i = 0; i < 2; i++) begin u_if.key_down = 1'b1; tick(); u_if.key_down = 1'b0; end
    chk("song_dn2", 32'(u_if.song), 3);
    u_if.key_up = 1'b1; u_if.key_down = 1'b1; tick(); u_if.key_up = 1'b0; u_if.key_down = 1'b0;
    chk("song_updn", 32'(u_if.song), 3);
    for (int i = 0; i < 7; i++) begin u_if.key_speed = 1'b1; tick(); u_if.key_speed = 1'b0; end
    chk("speed_wrap", 32'(u_if.speed), 1);
    u_if.key_speed = 1'b1; tick(); u_if.key_speed = 1'b0;
    chk("speed_2", 32'(u_if.speed), 2);

    // confirm beats key_up
    u_if.key_confirm = 1'b1; u_if.key_up = 1'b1;
    tick();
    u_if.key_confirm = 1'b0; u_if.key_up = 1'b0;
    chk("intro_state", 32'(u_if.state_dbg), 1);
    chk("intro_song",  32'(u_if.song), 3);
    chk("intro_menu",  32'(u_if.menu_enabled), 0);
    chk("intro_new1",  32'(u_if.new_signal), 1);
    u_if.in_animate_area = 1'b1;
    tick();
    chk("intro_new0", 32'(u_if.new_signal), 0);
    chk("intro_apd1", 32'(u_if.animate_pixel_disabled), 1);
    u_if.in_animate_area = 1'b0;
    tick();
    chk("intro_apd0", 32'(u_if.animate_pixel_disabled), 0);
    u_if.key_back = 1'b1; tick(); u_if.key_back = 1'b0;
    chk("intro_back", 32'(u_if.state_dbg), 0);
    chk("intro_back_menu", 32'(u_if.menu_enabled), 1);

    // animate_finish held from entry is ignored for the first INTRO cycle
    u_if.key_confirm = 1'b1; u_if.animate_finish = 1'b1;
    tick();
    u_if.key_confirm = 1'b0;
    chk("af_entry", 32'(u_if.state_dbg), 1);
    tick();
    chk("af_ignored", 32'(u_if.state_dbg), 1);
    tick();
    u_if.animate_finish = 1'b0;
    chk("arm_state", 32'(u_if.state_dbg), 2);
    chk("arm_rr", 32'(u_if.reset_restartable), 1);
    n = 1;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (u_if.reset_restartable) n++;
      if (u_if.play_game_out) break;
    end
    chk("arm_rr_cycles", 32'(n), 4);
    chk("play_state", 32'(u_if.state_dbg), 3);
    chk("play_en", 32'(u_if.play_game_out), 1);
    chk("play_rr0", 32'(u_if.reset_restartable), 0);

    // key_up in PLAY ignored
    u_if.key_up = 1'b1; tick(); u_if.key_up = 1'b0;
    chk("play_keyup", 32'(u_if.song), 3);

    // song_done wins over failed
    u_if.failed = 1'b1; u_if.song_done = 1'b1;
    tick();
    u_if.failed = 1'b0; u_if.song_done = 1'b0;
    chk("res_state", 32'(u_if.state_dbg), 4);
    chk("res_won", 32'(u_if.result_won), 1);
    chk("res_play0", 32'(u_if.play_game_out), 0);
    repeat (9) tick();
    chk("res_hold9", 32'(u_if.state_dbg), 4);
    tick();
    chk("res_hold10", 32'(u_if.state_dbg), 0);
    chk("res_hold_menu", 32'(u_if.menu_enabled), 1);

    // loss, then retry at cycle 5 with key_back also high
    go_play();
    chk("play2_state", 32'(u_if.state_dbg), 3);
    u_if.failed = 1'b1; tick(); u_if.failed = 1'b0;
    chk("res2_won", 32'(u_if.result_won), 0);
    repeat (4) tick();
    u_if.key_confirm = 1'b1; u_if.key_back = 1'b1;
    tick();
    u_if.key_confirm = 1'b0; u_if.key_back = 1'b0;
    chk("retry_state", 32'(u_if.state_dbg), 2);
    chk("retry_rr", 32'(u_if.reset_restartable), 1);
    chk("retry_song", 32'(u_if.song), 3);
    chk("retry_speed", 32'(u_if.speed), 2);
    repeat (4) tick();
    chk("retry_play", 32'(u_if.play_game_out), 1);
    u_if.key_back = 1'b1; tick(); u_if.key_back = 1'b0;
    chk("play_back", 32'(u_if.state_dbg), 0);
    chk("play_back_en", 32'(u_if.play_game_out), 0);

    // key_back in RESULT
    go_play();
    u_if.song_done = 1'b1; tick(); u_if.song_done = 1'b0;
    tick();
    u_if.key_back = 1'b1; tick(); u_if.key_back = 1'b0;
    chk("res_back", 32'(u_if.state_dbg), 0);

    // reset during ARM
    u_if.key_confirm = 1'b1; tick(); u_if.key_confirm = 1'b0;
    u_if.animate_finish = 1'b1; tick(); tick(); u_if.animate_finish = 1'b0;
    chk("arm2_state", 32'(u_if.state_dbg), 2);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rstarm_state", 32'(u_if.state_dbg), 0);
    chk("rstarm_song", 32'(u_if.song), 0);
    chk("rstarm_speed", 32'(u_if.speed), 1);
    chk("rstarm_rr", 32'(u_if.reset_restartable), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
